// File: rtl/frame_parity_checker.sv
// frame_parity_checker: serial frame parity check, DATA_BITS data bits + 1 parity bit per frame.
// Optional saturating errored-frame counter (errCount) compiled in with PARITY_ERR_COUNT_EN.
module frame_parity_checker #(
  parameter int DATA_BITS  = 8,
  parameter int ODD_PARITY = 0,
  parameter int CNT_WIDTH  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic dataIn,
  input  logic dataValid,
  input  logic frameAbort,
  output logic dataOut,
  output logic frameDone,
  output logic parityErr
`ifdef PARITY_ERR_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] errCount
`endif
);
  localparam int W = $clog2(DATA_BITS + 1);
  localparam logic [W-1:0] LAST = W'(DATA_BITS);
  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
  state_t state;
  logic [W-1:0] bitCnt;
  logic acc;
  logic err;
  logic accept_parity;
  assign err = acc ^ dataIn ^ (ODD_PARITY != 0);
  assign accept_parity = !frameAbort && dataValid && state == PARITY;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bitCnt    <= '0;
      acc       <= 1'b0;
      dataOut   <= 1'b1;
      frameDone <= 1'b0;
      parityErr <= 1'b0;
    end else if (frameAbort) begin
      state     <= IDLE;
      bitCnt    <= '0;
      acc       <= 1'b0;
      dataOut   <= 1'b1;
      frameDone <= 1'b0;
    end else if (!dataValid) begin
      frameDone <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          acc       <= dataIn;
          bitCnt    <= W'(1);
          dataOut   <= ~dataIn;
          frameDone <= 1'b0;
          state     <= (DATA_BITS == 1) ? PARITY : DATA;
        end
        DATA: begin
          acc       <= acc ^ dataIn;
          bitCnt    <= bitCnt + W'(1);
          dataOut   <= ~(acc ^ dataIn);
          frameDone <= 1'b0;
          state     <= (bitCnt + W'(1) == LAST) ? PARITY : DATA;
        end
        PARITY: begin
          acc       <= 1'b0;
          bitCnt    <= '0;
          dataOut   <= 1'b1;
          frameDone <= 1'b1;
          parityErr <= err;
          state     <= IDLE;
        end
        default: begin
          acc       <= 1'b0;
          bitCnt    <= '0;
          dataOut   <= 1'b1;
          frameDone <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
`ifdef PARITY_ERR_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) errCount <= '0;
    else if (accept_parity && err && errCount != '1) errCount <= errCount + CNT_WIDTH'(1);
  end
`else
  logic unused_ok;
  assign unused_ok = accept_parity;
`endif
endmodule
